// File: rtl/lsu_access_splitter_pkg.sv
// Shared types and constants for the LSU access splitter: size encodings,
// FSM states, request part payload and a byte-lane mask helper.
package lsu_access_splitter_pkg;

    localparam int unsigned LINE_BYTES_DEF = 32;
    localparam int unsigned PAGE_BYTES_DEF = 4096;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;
    localparam logic [1:0] SZ_8B = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE1  = 2'd1,
        ST_ISSUE2  = 2'd2,
        ST_WAIT_RD = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  size;
        logic [63:0] data;
    } part_t;

    // Ones in the low nbytes byte lanes, zero above.
    function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                m[8*i +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_access_splitter_if.sv
// Upstream access, downstream request and read-return signals of the splitter.
interface lsu_access_splitter_if;
    logic        LA_V;
    logic [31:0] LA_ADDR;
    logic [1:0]  LA_SIZE;
    logic        LA_RW;
    logic [63:0] LA_WR_DATA;
    logic        LA_STALL;
    logic        REQ_V;
    logic [31:0] REQ_ADDR;
    logic [3:0]  REQ_SIZE;
    logic        REQ_RW;
    logic [63:0] REQ_WR_DATA;
    logic        REQ_LAST;
    logic        REQ_PG_X;
    logic        REQ_STALL;
    logic        RD_V;
    logic [63:0] RD_DATA;
    logic        RSP_V;
    logic [63:0] RSP_DATA;

    modport master (
        output LA_V, LA_ADDR, LA_SIZE, LA_RW, LA_WR_DATA, REQ_STALL, RD_V, RD_DATA,
        input  LA_STALL, REQ_V, REQ_ADDR, REQ_SIZE, REQ_RW, REQ_WR_DATA, REQ_LAST,
               REQ_PG_X, RSP_V, RSP_DATA
    );

    modport slave (
        input  LA_V, LA_ADDR, LA_SIZE, LA_RW, LA_WR_DATA, REQ_STALL, RD_V, RD_DATA,
        output LA_STALL, REQ_V, REQ_ADDR, REQ_SIZE, REQ_RW, REQ_WR_DATA, REQ_LAST,
               REQ_PG_X, RSP_V, RSP_DATA
    );
endinterface

// File: rtl/lsu_access_splitter_split_calc.sv
// Combinational split decision: part sizes, second-part address, page-cross
// flag and per-part write data for one linear access.
module lsu_access_splitter_split_calc
    import lsu_access_splitter_pkg::*;
#(
    parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
    parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEF
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [63:0] i_wr_data,
    output logic        o_split_c,
    output part_t       o_part1_c,
    output part_t       o_part2_c,
    output logic        o_pg_x_c
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned OFF_P1 = OFF_W + 1;
    localparam int unsigned HI_W   = 32 - OFF_W;
    localparam int unsigned PG_W   = $clog2(PAGE_BYTES);
    localparam logic [OFF_W:0] LB  = OFF_P1'(LINE_BYTES);

    logic [3:0]      w_n;
    logic [OFF_W:0]  w_end;
    logic [OFF_W:0]  w_rem;
    logic [3:0]      w_s1;
    logic [3:0]      w_s2;
    logic [HI_W-1:0] w_line2;
    logic [31:0]     w_addr2;
    logic [6:0]      w_sh;

    always_comb begin
        w_n = 4'd1;
        case (i_size)
            SZ_1B:   w_n = 4'd1;
            SZ_2B:   w_n = 4'd2;
            SZ_4B:   w_n = 4'd4;
            SZ_8B:   w_n = 4'd8;
            default: w_n = 4'd1;
        endcase
    end

    assign w_end     = {1'b0, i_addr[OFF_W-1:0]} + OFF_P1'(w_n);
    assign w_rem     = LB - {1'b0, i_addr[OFF_W-1:0]};
    assign o_split_c = (w_end > LB);
    assign w_s1      = o_split_c ? 4'(w_rem) : w_n;
    assign w_s2      = w_n - w_s1;

    // Next line index wraps modulo 2^32 at the top of the address space.
    assign w_line2   = i_addr[31:OFF_W] + HI_W'(1);
    assign w_addr2   = {w_line2, {OFF_W{1'b0}}};
    assign o_pg_x_c  = (w_addr2[PG_W-1:0] == '0);
    assign w_sh      = {w_s1, 3'b000};

    assign o_part1_c.addr = i_addr;
    assign o_part1_c.size = w_s1;
    assign o_part1_c.data = i_wr_data & byte_mask(w_s1);
    assign o_part2_c.addr = w_addr2;
    assign o_part2_c.size = w_s2;
    assign o_part2_c.data = (i_wr_data >> w_sh) & byte_mask(w_s2);

endmodule

// File: rtl/lsu_access_splitter.sv
// Splits a line-crossing LSU access into two downstream requests and merges
// the two returned read parts into one right-justified response.
module lsu_access_splitter
    import lsu_access_splitter_pkg::*;
#(
    parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
    parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_access_splitter_if.slave  bus
);
    state_t      r_state;
    logic        r_la_stall;
    logic        r_req_v;
    part_t       r_req;
    logic        r_req_rw;
    logic        r_req_last;
    logic        r_req_pg_x;
    logic        r_rsp_v;
    logic [63:0] r_rsp_data;
    logic        r_split;
    logic        r_rw;
    logic [3:0]  r_s1;
    part_t       r_part2;
    logic        r_pg_x;
    logic [1:0]  r_pending;
    logic        r_rd_idx;
    logic [63:0] r_merge;

    logic        w_split;
    part_t       w_part1;
    part_t       w_part2;
    logic        w_pg_x;
    logic        w_accept;
    logic        w_rd_take;
    logic        w_rd_last;
    logic [63:0] w_merge_next;

    lsu_access_splitter_split_calc #(
        .LINE_BYTES (LINE_BYTES),
        .PAGE_BYTES (PAGE_BYTES)
    ) u_calc (
        .i_addr     (bus.LA_ADDR),
        .i_size     (bus.LA_SIZE),
        .i_wr_data  (bus.LA_WR_DATA),
        .o_split_c  (w_split),
        .o_part1_c  (w_part1),
        .o_part2_c  (w_part2),
        .o_pg_x_c   (w_pg_x)
    );

    assign w_accept  = ((r_state == ST_ISSUE1) || (r_state == ST_ISSUE2)) && !bus.REQ_STALL && !r_rw;
    assign w_rd_take = bus.RD_V && (r_pending != 2'd0);
    assign w_rd_last = w_rd_take && (r_state == ST_WAIT_RD) && (r_pending == 2'd1);

    // Part 1 fills the low s1 bytes; part 2 is placed directly above it.
    assign w_merge_next = !r_rd_idx
        ? (bus.RD_DATA & byte_mask(r_s1))
        : (r_merge | ((bus.RD_DATA & byte_mask(r_part2.size)) << {r_s1, 3'b000}));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_la_stall <= 1'b0;
            r_req_v    <= 1'b0;
            r_req      <= '0;
            r_req_rw   <= 1'b0;
            r_req_last <= 1'b0;
            r_req_pg_x <= 1'b0;
            r_rsp_v    <= 1'b0;
            r_rsp_data <= '0;
            r_split    <= 1'b0;
            r_rw       <= 1'b0;
            r_s1       <= '0;
            r_part2    <= '0;
            r_pg_x     <= 1'b0;
            r_pending  <= '0;
            r_rd_idx   <= 1'b0;
            r_merge    <= '0;
        end else begin
            r_rsp_v   <= 1'b0;
            r_pending <= r_pending + 2'(w_accept) - 2'(w_rd_take);
            if (w_rd_take) begin
                r_merge  <= w_merge_next;
                r_rd_idx <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.LA_V) begin
                        r_split    <= w_split;
                        r_rw       <= bus.LA_RW;
                        r_s1       <= w_part1.size;
                        r_part2    <= w_part2;
                        r_pg_x     <= w_pg_x;
                        r_rd_idx   <= 1'b0;
                        r_req_v    <= 1'b1;
                        r_req      <= w_part1;
                        r_req_rw   <= bus.LA_RW;
                        r_req_last <= !w_split;
                        r_req_pg_x <= 1'b0;
                        r_la_stall <= 1'b1;
                        r_state    <= ST_ISSUE1;
                    end
                end
                ST_ISSUE1: begin
                    if (!bus.REQ_STALL) begin
                        if (r_split) begin
                            r_req      <= r_part2;
                            r_req_last <= 1'b1;
                            r_req_pg_x <= r_pg_x;
                            r_state    <= ST_ISSUE2;
                        end else begin
                            r_req_v    <= 1'b0;
                            r_req      <= '0;
                            r_req_rw   <= 1'b0;
                            r_req_last <= 1'b0;
                            r_req_pg_x <= 1'b0;
                            r_la_stall <= !r_rw;
                            r_state    <= r_rw ? ST_IDLE : ST_WAIT_RD;
                        end
                    end
                end
                ST_ISSUE2: begin
                    if (!bus.REQ_STALL) begin
                        r_req_v    <= 1'b0;
                        r_req      <= '0;
                        r_req_rw   <= 1'b0;
                        r_req_last <= 1'b0;
                        r_req_pg_x <= 1'b0;
                        r_la_stall <= !r_rw;
                        r_state    <= r_rw ? ST_IDLE : ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (w_rd_last) begin
                        r_rsp_v    <= 1'b1;
                        r_rsp_data <= w_merge_next;
                        r_la_stall <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.LA_STALL    = r_la_stall;
    assign bus.REQ_V       = r_req_v;
    assign bus.REQ_ADDR    = r_req.addr;
    assign bus.REQ_SIZE    = r_req.size;
    assign bus.REQ_RW      = r_req_rw;
    assign bus.REQ_WR_DATA = r_req.data;
    assign bus.REQ_LAST    = r_req_last;
    assign bus.REQ_PG_X    = r_req_pg_x;
    assign bus.RSP_V       = r_rsp_v;
    assign bus.RSP_DATA    = r_rsp_data;

endmodule

// File: tb/tb_lsu_access_splitter.sv
// Testbench for lsu_access_splitter: directed table, stall/reset sequences and
// random accesses checked against a byte-level reference model.
module tb_lsu_access_splitter;
    localparam int unsigned LINE = 32;
    localparam int unsigned PAGE = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_access_splitter_if bus();

    lsu_access_splitter #(.LINE_BYTES(LINE), .PAGE_BYTES(PAGE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observed downstream parts and response of the current access
    int          obs_n;
    logic [31:0] obs_addr [4];
    logic [3:0]  obs_size [4];
    logic [63:0] obs_data [4];
    logic        obs_last [4];
    logic        obs_pgx  [4];
    logic        obs_rw   [4];
    int          obs_cyc  [4];
    int          rsp_cnt;
    logic [63:0] rsp_val;
    logic [63:0] rd_src [2];

    // Expected parts and response
    int          exp_n;
    logic [31:0] exp_addr [2];
    int          exp_size [2];
    logic [63:0] exp_data [2];
    logic        exp_pgx  [2];
    logic [63:0] exp_rsp;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        rw;
        logic [63:0] wdata;
        logic [63:0] rd0;
        logic [63:0] rd1;
        int          parts;
        logic [31:0] a0;
        int          s0;
        logic [63:0] d0;
        logic [31:0] a1;
        int          s1;
        logic [63:0] d1;
        logic        pg1;
        logic [63:0] rsp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-level model: every byte of the access goes to the part of its cache line.
    task automatic model(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] wdata);
        int n;
        int k;
        int idx;
        logic [31:0] a;
        n = 1 << size;
        exp_n = 0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (i == 0 || (a % LINE) == 0) begin
                exp_addr[exp_n] = a;
                exp_size[exp_n] = 0;
                exp_data[exp_n] = '0;
                exp_pgx[exp_n]  = (i != 0) && ((a % PAGE) == 0);
                exp_n++;
            end
            k = exp_n - 1;
            exp_data[k][8*exp_size[k] +: 8] = wdata[8*i +: 8];
            exp_size[k]++;
        end
        exp_rsp = '0;
        idx = 0;
        for (int p = 0; p < exp_n; p++) begin
            for (int j = 0; j < exp_size[p]; j++) begin
                exp_rsp[8*idx +: 8] = rd_src[p][8*j +: 8];
                idx++;
            end
        end
    endtask

    // Drives one access from an idle negedge and records everything up to idle.
    // mode 0: no stall, immediate returns; 1: 3-cycle stall first; 2: random.
    task automatic do_access(input logic [31:0] addr, input logic [1:0] size, input logic rw,
                             input logic [63:0] wdata, input int mode);
        int cyc;
        int n_acc;
        int n_ret;
        int stall_left;
        logic st;
        logic prev_stall;
        logic [127:0] prev;
        logic [127:0] cur;
        obs_n = 0; rsp_cnt = 0; rsp_val = '0; n_acc = 0; n_ret = 0;
        stall_left = (mode == 1) ? 3 : 0;
        prev_stall = 1'b0; prev = '0;
        bus.LA_V = 1'b1; bus.LA_ADDR = addr; bus.LA_SIZE = size;
        bus.LA_RW = rw; bus.LA_WR_DATA = wdata;
        @(negedge clk);
        bus.LA_V = 1'b0;
        chk("latency_req_v", 128'(bus.REQ_V), 128'(1));
        chk("la_stall_busy", 128'(bus.LA_STALL), 128'(1));
        for (cyc = 0; cyc < 100; cyc++) begin
            if (bus.RSP_V) begin
                rsp_cnt++;
                rsp_val = bus.RSP_DATA;
            end
            if (!bus.LA_STALL) break;
            cur = 128'({bus.REQ_V, bus.REQ_ADDR, bus.REQ_SIZE, bus.REQ_RW,
                        bus.REQ_WR_DATA, bus.REQ_LAST, bus.REQ_PG_X});
            if (prev_stall) chk("req_stable", cur, prev);
            if (n_acc > n_ret && n_ret < 2 && (mode != 2 || $urandom_range(0, 1) == 1)) begin
                bus.RD_V = 1'b1;
                bus.RD_DATA = rd_src[n_ret];
                n_ret++;
            end else begin
                bus.RD_V = 1'b0;
                bus.RD_DATA = {$urandom, $urandom};
            end
            if (mode == 1) begin
                st = (stall_left > 0);
                if (st) stall_left--;
            end else if (mode == 2) begin
                st = ($urandom_range(0, 2) == 0);
            end else begin
                st = 1'b0;
            end
            bus.REQ_STALL = st;
            prev_stall = st && bus.REQ_V;
            prev = cur;
            if (bus.REQ_V && !st) begin
                if (obs_n < 4) begin
                    obs_addr[obs_n] = bus.REQ_ADDR; obs_size[obs_n] = bus.REQ_SIZE;
                    obs_data[obs_n] = bus.REQ_WR_DATA; obs_last[obs_n] = bus.REQ_LAST;
                    obs_pgx[obs_n] = bus.REQ_PG_X; obs_rw[obs_n] = bus.REQ_RW;
                    obs_cyc[obs_n] = cyc;
                end
                obs_n++;
                if (!rw) n_acc++;
            end
            @(negedge clk);
        end
        if (cyc >= 100) begin
            n_vec++; n_err++;
            $display("FAIL access_timeout: LA_STALL still 1 after 100 cycles, addr 0x%0h", addr);
        end
        bus.RD_V = 1'b0;
        bus.REQ_STALL = 1'b0;
        chk("req_v_after", 128'(bus.REQ_V), 128'(0));
        @(negedge clk);
        chk("rsp_v_pulse", 128'(bus.RSP_V), 128'(0));
    endtask

    task automatic compare_obs(input logic rw);
        chk("part_count", 128'(obs_n), 128'(exp_n));
        for (int k = 0; k < exp_n && k < obs_n; k++) begin
            chk("part_addr", 128'(obs_addr[k]), 128'(exp_addr[k]));
            chk("part_size", 128'(obs_size[k]), 128'(exp_size[k]));
            chk("part_data", 128'(obs_data[k]), 128'(exp_data[k]));
            chk("part_last", 128'(obs_last[k]), 128'(k == exp_n - 1));
            chk("part_pg_x", 128'(obs_pgx[k]), 128'(exp_pgx[k]));
            chk("part_rw",   128'(obs_rw[k]), 128'(rw));
        end
        chk("rsp_count", 128'(rsp_cnt), 128'(rw ? 0 : 1));
        if (!rw) chk("rsp_data", 128'(rsp_val), 128'(exp_rsp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [1:0]  size;
        logic        rw;
        logic [63:0] wdata;

        vecs[0] = '{32'h0200004A, 2'b11, 1'b0, 64'h0, 64'h1122334455667788, 64'h0,
                    1, 32'h0200004A, 8, 64'h0, 32'h0, 0, 64'h0, 1'b0, 64'h1122334455667788};
        vecs[1] = '{32'h02000FFF, 2'b10, 1'b0, 64'h0, 64'hAA, 64'hDDCCBB,
                    2, 32'h02000FFF, 1, 64'h0, 32'h02001000, 3, 64'h0, 1'b1, 64'h00000000DDCCBBAA};
        vecs[2] = '{32'h0400003A, 2'b11, 1'b1, 64'h8877665544332211, 64'h0, 64'h0,
                    2, 32'h0400003A, 6, 64'h665544332211, 32'h04000040, 2, 64'h8877, 1'b0, 64'h0};
        vecs[3] = '{32'hFFFFFFFE, 2'b10, 1'b0, 64'h0, 64'hBBAA, 64'hDDCC,
                    2, 32'hFFFFFFFE, 2, 64'h0, 32'h00000000, 2, 64'h0, 1'b1, 64'hDDCCBBAA};

        bus.LA_V = 1'b0; bus.LA_ADDR = '0; bus.LA_SIZE = '0; bus.LA_RW = 1'b0;
        bus.LA_WR_DATA = '0; bus.REQ_STALL = 1'b0; bus.RD_V = 1'b0; bus.RD_DATA = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_v",    128'(bus.REQ_V), 128'(0));
        chk("rst_la_stall", 128'(bus.LA_STALL), 128'(0));
        chk("rst_rsp_v",    128'(bus.RSP_V), 128'(0));
        chk("rst_rsp_data", 128'(bus.RSP_DATA), 128'(0));
        chk("rst_req_addr", 128'(bus.REQ_ADDR), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < 4; v++) begin
            rd_src[0] = vecs[v].rd0;
            rd_src[1] = vecs[v].rd1;
            do_access(vecs[v].addr, vecs[v].size, vecs[v].rw, vecs[v].wdata, 0);
            exp_n = vecs[v].parts;
            exp_addr[0] = vecs[v].a0; exp_size[0] = vecs[v].s0; exp_data[0] = vecs[v].d0; exp_pgx[0] = 1'b0;
            exp_addr[1] = vecs[v].a1; exp_size[1] = vecs[v].s1; exp_data[1] = vecs[v].d1; exp_pgx[1] = vecs[v].pg1;
            exp_rsp = vecs[v].rsp;
            compare_obs(vecs[v].rw);
        end

        // Downstream stall for three cycles on part 1 of a split read
        rd_src[0] = 64'h11; rd_src[1] = 64'h443322;
        do_access(32'h02000FFF, 2'b10, 1'b0, 64'h0, 1);
        model(32'h02000FFF, 2'b10, 64'h0);
        compare_obs(1'b0);
        chk("stall_part1_cycle", 128'(obs_cyc[0]), 128'(3));
        chk("stall_part2_gap",   128'(obs_cyc[1] - obs_cyc[0]), 128'(1));

        // Reset while issuing part 2; later returns must be ignored
        bus.LA_V = 1'b1; bus.LA_ADDR = 32'h02000FFF; bus.LA_SIZE = 2'b10; bus.LA_RW = 1'b0;
        bus.LA_WR_DATA = '0;
        @(negedge clk);
        bus.LA_V = 1'b0;
        @(negedge clk);
        chk("issue2_valid", 128'({bus.REQ_V, bus.REQ_LAST}), 128'(2'b11));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_req_v",    128'(bus.REQ_V), 128'(0));
        chk("midrst_la_stall", 128'(bus.LA_STALL), 128'(0));
        chk("midrst_rsp_data", 128'(bus.RSP_DATA), 128'(0));
        bus.RD_V = 1'b1; bus.RD_DATA = 64'hDEADBEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 128'(bus.RSP_V), 128'(0));
            chk("midrst_idle",   128'(bus.LA_STALL), 128'(0));
        end
        bus.RD_V = 1'b0;
        @(negedge clk);

        // Random accesses, biased toward line/page/address-space ends
        for (int t = 0; t < 250; t++) begin
            addr = $urandom;
            case ($urandom_range(0, 3))
                0: addr[4:0] = 5'(32 - $urandom_range(1, 8));
                1: begin addr[11:0] = 12'hFE0; addr[4:0] = 5'(32 - $urandom_range(1, 8)); end
                2: begin addr = 32'hFFFFFFE0; addr[4:0] = 5'(32 - $urandom_range(1, 8)); end
                default: ;
            endcase
            size  = 2'($urandom_range(0, 3));
            rw    = 1'($urandom_range(0, 1));
            wdata = {$urandom, $urandom};
            rd_src[0] = {$urandom, $urandom};
            rd_src[1] = {$urandom, $urandom};
            do_access(addr, size, rw, wdata, ($urandom_range(0, 3) == 0) ? 0 : 2);
            model(addr, size, wdata);
            compare_obs(rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
